// File: rtl/inst_fetch_responder_pkg.sv
// Shared widths, FSM encodings and payload types for the instruction fetch responder.
package inst_fetch_responder_pkg;

  localparam int unsigned InstAddrWidth            = 32;
  localparam int unsigned CacheDisposeInstNumWidth = 2;
  localparam int unsigned BeatWidth                = 32;
  localparam int unsigned FetchWidth               = 2 * BeatWidth;

  // Responder FSM: serves the request queue head with one 2-beat burst
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_BEAT0 = 3'd2,
    ST_BEAT1 = 3'd3,
    ST_RESP  = 3'd4
  } ifr_state_e;

  // 64-bit fetch payload returned to the IF stage: {word@addr+4, word@addr}
  typedef struct packed {
    logic [BeatWidth-1:0] hi;
    logic [BeatWidth-1:0] lo;
  } fetch_data_t;

endpackage

// File: rtl/inst_fetch_responder_req_fifo.sv
// ifr_req_fifo: DEPTH-entry synchronous FIFO holding accepted fetch addresses.
module ifr_req_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]    mem [DEPTH];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;

  // Pointers wrap modulo DEPTH, so count alone tells full from empty
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only observed while count is non-zero
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/inst_fetch_responder.sv
// Memory-side responder for the IF request/data_ok protocol: queues fetch
// requests and serves each, in order, with a 2-beat 32-bit memory burst.
module inst_fetch_responder
  import inst_fetch_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = InstAddrWidth,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = CacheDisposeInstNumWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic [ADDR_W-1:0]     req_addr_i,
  output logic                  addr_ok_o,
  output logic                  data_ok_o,
  output logic [FetchWidth-1:0] rdata_o,
  output logic [CNT_W-1:0]      dispose_num_o,
  output logic                  rd_req_o,
  output logic [ADDR_W-1:0]     rd_addr_o,
  input  logic                  rd_ready_i,
  input  logic                  rd_valid_i,
  input  logic [BeatWidth-1:0]  rd_data_i,
  input  logic                  rd_last_i,
  output logic                  error_o
);

  ifr_state_e        state_q;
  ifr_state_e        state_d;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ADDR_W-1:0] head_addr;
  logic [CNT_W-1:0]  count;
  fetch_data_t       beat_q;
  logic              err_set;
  logic              unused_low_bits;

  // Acceptance uses the registered count: a full queue cannot accept even on its pop cycle
  assign push = req_i & ~fifo_full;
  assign pop  = (state_q == ST_RESP);

  ifr_req_fifo #(
    .W     (ADDR_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_req_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (req_addr_i),
    .head  (head_addr),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Byte offset within the 64-bit fetch is not used by the burst
  assign unused_low_bits = ^head_addr[2:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; IDLE also wakes on a push so rd_req follows addr_ok by one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_empty || push) state_d = ST_ADDR;
      ST_ADDR:  if (rd_ready_i)          state_d = ST_BEAT0;
      ST_BEAT0: if (rd_valid_i)          state_d = ST_BEAT1;
      ST_BEAT1: if (rd_valid_i)          state_d = ST_RESP;
      // A same-cycle push at count==1 is not yet visible, so it restarts from IDLE
      ST_RESP:  state_d = (count > CNT_W'(1)) ? ST_ADDR : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    addr_ok_o = 1'b0;
    rd_req_o  = 1'b0;
    data_ok_o = 1'b0;
    rd_addr_o = '0;
    addr_ok_o = push;
    rd_req_o  = (state_q == ST_ADDR);
    data_ok_o = (state_q == ST_RESP);
    rd_addr_o = {head_addr[ADDR_W-1:3], 3'b000};
  end

  // Protocol violations: wrong last marker, or a beat outside the beat window
  always_comb begin
    err_set = 1'b0;
    if (rd_valid_i) begin
      case (state_q)
        ST_BEAT0: err_set = rd_last_i;
        ST_BEAT1: err_set = ~rd_last_i;
        default:  err_set = 1'b1;
      endcase
    end
  end

  // Beat assembly and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q  <= '0;
      error_o <= 1'b0;
    end else begin
      if (state_q == ST_BEAT0 && rd_valid_i) beat_q.lo <= rd_data_i;
      if (state_q == ST_BEAT1 && rd_valid_i) beat_q.hi <= rd_data_i;
      if (err_set) error_o <= 1'b1;
    end
  end

  assign rdata_o       = beat_q;
  assign dispose_num_o = count;

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Self-checking bench for inst_fetch_responder: transaction-level model of the
// request queue plus a reactive memory responder, checked every cycle.
module tb_inst_fetch_responder;

  logic        clk;
  logic        rst;
  logic        req_i;
  logic [31:0] req_addr_i;
  logic        addr_ok_o;
  logic        data_ok_o;
  logic [63:0] rdata_o;
  logic [1:0]  dispose_num_o;
  logic        rd_req_o;
  logic [31:0] rd_addr_o;
  logic        rd_ready_i;
  logic        rd_valid_i;
  logic [31:0] rd_data_i;
  logic        rd_last_i;
  logic        error_o;

  inst_fetch_responder dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req_i),
    .req_addr_i    (req_addr_i),
    .addr_ok_o     (addr_ok_o),
    .data_ok_o     (data_ok_o),
    .rdata_o       (rdata_o),
    .dispose_num_o (dispose_num_o),
    .rd_req_o      (rd_req_o),
    .rd_addr_o     (rd_addr_o),
    .rd_ready_i    (rd_ready_i),
    .rd_valid_i    (rd_valid_i),
    .rd_data_i     (rd_data_i),
    .rd_last_i     (rd_last_i),
    .error_o       (error_o)
  );

  always #5 clk = ~clk;

  // Model: queue of accepted requests; only the head is in service
  typedef struct {
    logic [31:0] addr;
    int          acc;
  } ent_t;

  ent_t q[$];
  int   h_start, h_beats, cyc;
  bit   h_aacc, m_err;

  // Stimulus knobs
  bit          d_rst, d_req, inj_last, inj_spur;
  logic [31:0] d_addr;
  int          p_ready, p_valid;

  // Last sampled outputs
  logic        s_aok, s_dok, s_rdreq, s_err;
  logic [1:0]  s_disp;
  logic [31:0] s_raddr;
  logic [63:0] s_rdata;

  int n_cmp, n_bad;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h1C00_0000) return 32'h1111_1111;
    if (a == 32'h1C00_0004) return 32'h2222_2222;
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h0F1E};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s cyc=%0d bound expired", nm, cyc);
  endtask

  // One clock: drive inputs, compare against the model, advance the model
  task automatic cycle();
    bit          win, e_aok, e_rdreq, e_dok;
    logic [31:0] al;
    @(posedge clk);
    #1;
    rst        = d_rst;
    req_i      = d_req & !d_rst;
    req_addr_i = d_addr;
    rd_ready_i = ($urandom_range(99) < p_ready);
    win = (q.size() > 0) && h_aacc && (h_beats < 2);
    al  = (q.size() > 0) ? (q[0].addr & ~32'h7) : 32'h0;
    rd_valid_i = 1'b0;
    rd_last_i  = 1'b0;
    rd_data_i  = $urandom;
    if (!d_rst && win && ($urandom_range(99) < p_valid)) begin
      rd_valid_i = 1'b1;
      rd_data_i  = memfn(al + 32'(4 * h_beats));
      rd_last_i  = (h_beats == 1);
      if (inj_last && h_beats == 0) begin
        rd_last_i = 1'b1;
        inj_last  = 1'b0;
      end
    end else if (!d_rst && inj_spur && q.size() == 0) begin
      rd_valid_i = 1'b1;
      inj_spur   = 1'b0;
    end
    #1;
    e_aok   = req_i && (q.size() < 2);
    e_rdreq = (q.size() > 0) && (cyc >= h_start) && !h_aacc;
    e_dok   = (q.size() > 0) && (h_beats == 2);
    s_aok = addr_ok_o;  s_dok = data_ok_o;  s_rdreq = rd_req_o;  s_err = error_o;
    s_disp = dispose_num_o;  s_raddr = rd_addr_o;  s_rdata = rdata_o;
    if (!d_rst) begin
      chk("addr_ok", s_aok, e_aok);
      chk("dispose", s_disp, q.size());
      chk("rd_req", s_rdreq, e_rdreq);
      if (e_rdreq) chk("rd_addr", s_raddr, al);
      chk("data_ok", s_dok, e_dok);
      if (e_dok) chk("rdata", s_rdata, {memfn(al + 32'd4), memfn(al)});
      chk("error", s_err, m_err);
    end
    if (d_rst) begin
      q.delete();
      h_aacc = 0; h_beats = 0; h_start = 0; m_err = 0;
    end else begin
      if (rd_valid_i) begin
        if (win) begin
          if (h_beats == 0 && rd_last_i)  m_err = 1;
          if (h_beats == 1 && !rd_last_i) m_err = 1;
          h_beats++;
        end else m_err = 1;
      end
      if (e_rdreq && rd_ready_i) h_aacc = 1;
      if (e_dok) begin
        void'(q.pop_front());
        h_aacc = 0; h_beats = 0;
        if (q.size() > 0) h_start = cyc + 1;
      end
      if (e_aok) begin
        q.push_back('{addr: d_addr, acc: cyc});
        if (q.size() == 1) h_start = e_dok ? cyc + 2 : cyc + 1;
      end
    end
    cyc++;
  endtask

  task automatic send(input logic [31:0] a);
    int n;
    d_req = 1; d_addr = a; n = 0;
    do begin cycle(); n++; end while (!s_aok && n < 50);
    if (!s_aok) bound_fail("send_timeout");
    d_req = 0;
  endtask

  task automatic drain(output int ndok);
    int n;
    ndok = 0; n = 0;
    while (q.size() > 0 && n < 300) begin
      cycle();
      if (s_dok) ndok++;
      n++;
    end
    if (q.size() > 0) bound_fail("drain_timeout");
  endtask

  task automatic do_reset();
    d_rst = 1; d_req = 0;
    cycle();
    d_rst = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   nd, n;
    logic pd;
    clk = 0; rst = 1; req_i = 0; req_addr_i = 0;
    rd_ready_i = 0; rd_valid_i = 0; rd_data_i = 0; rd_last_i = 0;
    n_cmp = 0; n_bad = 0; cyc = 0;
    h_start = 0; h_beats = 0; h_aacc = 0; m_err = 0;
    d_rst = 1; d_req = 0; d_addr = 0; inj_last = 0; inj_spur = 0;
    p_ready = 100; p_valid = 100;
    repeat (3) cycle();
    d_rst = 0;
    cycle();
    chk("rst_aok", s_aok, 0);
    chk("rst_dok", s_dok, 0);
    chk("rst_rdreq", s_rdreq, 0);
    chk("rst_disp", s_disp, 0);
    chk("rst_err", s_err, 0);

    // Single request at minimum latency
    d_req = 1; d_addr = 32'h1C00_0004;
    cycle();
    chk("t1_aok", s_aok, 1);
    d_req = 0;
    for (int k = 1; k <= 5; k++) begin
      cycle();
      if (k == 1) begin
        chk("t1_rdreq", s_rdreq, 1);
        chk("t1_rdaddr", s_raddr, 32'h1C00_0000);
        chk("t1_disp1", s_disp, 1);
      end
      if (k == 4) begin
        chk("t1_dok", s_dok, 1);
        chk("t1_rdata", s_rdata, 64'h2222_2222_1111_1111);
      end
      if (k == 5) chk("t1_disp0", s_disp, 0);
    end

    // Three consecutive requests against a 2-entry queue
    d_req = 1; d_addr = 32'h0000_1000; cycle(); chk("t2_aok0", s_aok, 1);
    d_addr = 32'h0000_2008;            cycle(); chk("t2_aok1", s_aok, 1);
    d_addr = 32'h0000_3010;            cycle(); chk("t2_aok2", s_aok, 0);
    chk("t2_disp_full", s_disp, 2);
    n = 0;
    do begin pd = s_dok; cycle(); n++; end while (!s_aok && n < 20);
    if (s_aok) chk("t2_acc_after_dok", pd, 1);
    else bound_fail("t2_third_accept");
    d_req = 0;
    drain(nd);

    // Address backpressure, then gapped beats
    p_ready = 0;
    send(32'h0ABC_DEF4);
    repeat (5) cycle();
    chk("t3_rdreq_held", s_rdreq, 1);
    p_ready = 100; p_valid = 30;
    drain(nd);
    chk("t3_one_dok", nd, 1);

    // Push in the RESP cycle with one outstanding
    p_valid = 100;
    repeat (2) cycle();
    send(32'h4000_0100);
    repeat (3) cycle();
    d_req = 1; d_addr = 32'h5000_0208;
    cycle();
    chk("t4_dok", s_dok, 1);
    chk("t4_aok", s_aok, 1);
    d_req = 0;
    cycle();
    chk("t4_disp", s_disp, 1);
    chk("t4_rdreq_gap", s_rdreq, 0);
    cycle();
    chk("t4_rdreq", s_rdreq, 1);
    drain(nd);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if (i % 400 == 0) begin
        p_ready = $urandom_range(100, 20);
        p_valid = $urandom_range(100, 20);
      end
      d_req  = $urandom_range(1);
      d_addr = $urandom;
      cycle();
    end
    d_req = 0;
    drain(nd);

    // Spurious beat while idle
    cycle();
    inj_spur = 1;
    cycle();
    cycle();
    chk("t5_spur_err", s_err, 1);
    do_reset();
    cycle();
    chk("t5_err_cleared", s_err, 0);

    // rd_last on the first beat
    p_ready = 100; p_valid = 100; inj_last = 1;
    send(32'h7000_0020);
    drain(nd);
    chk("t5_last_err", s_err, 1);
    repeat (3) cycle();
    chk("t5_err_sticky", s_err, 1);

    // Reset while the burst is in its second beat
    do_reset();
    cycle();
    p_valid = 100;
    send(32'h6000_0040);
    n = 0;
    while (h_beats != 1 && n < 20) begin cycle(); n++; end
    if (h_beats != 1) bound_fail("t6_reach_beat1");
    p_valid = 0;
    do_reset();
    cycle();
    chk("t6_aok", s_aok, 0);
    chk("t6_dok", s_dok, 0);
    chk("t6_rdreq", s_rdreq, 0);
    chk("t6_disp", s_disp, 0);
    chk("t6_err", s_err, 0);
    chk("t6_rdata", s_rdata, 0);
    p_valid = 100;
    send(32'h6000_0048);
    drain(nd);
    chk("t6_served", nd, 1);
    repeat (2) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
